// File: rtl/axicb_pipe_arbiter_if.sv
// Handshake bundle for the pipelined round-robin arbiter: NB_REQ requester
// channels on the input side, one registered channel on the output side.
interface axicb_pipe_arbiter_if #(
  parameter int NB_REQ     = 4,
  parameter int DATA_BUS_W = 8
);
  logic [NB_REQ-1:0]            i_valid;
  logic [NB_REQ-1:0]            i_ready;
  logic [NB_REQ*DATA_BUS_W-1:0] i_data;
  logic [NB_REQ-1:0]            i_last;
  logic                         o_valid;
  logic                         o_ready;
  logic [DATA_BUS_W-1:0]        o_data;
  logic                         o_last;
  logic [NB_REQ-1:0]            o_grant;

  // Arbiter side.
  modport slave (
    input  i_valid, i_data, i_last, o_ready,
    output i_ready, o_valid, o_data, o_last, o_grant
  );

  // Requester / downstream side.
  modport master (
    output i_valid, i_data, i_last, o_ready,
    input  i_ready, o_valid, o_data, o_last, o_grant
  );
endinterface

// File: rtl/axicb_pipe_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready channel between
// NB_REQ requesters. PKT_MODE=1 holds the grant until the beat carrying last
// is accepted; PKT_MODE=0 rotates priority after every accepted beat.

// Per-requester slice: ready generation and AND-masked payload for the
// OR-reduction mux in the top.
module axicb_pipe_arbiter_lane #(
  parameter int DATA_BUS_W = 8
) (
  input  logic                  hit,
  input  logic                  en,
  input  logic                  valid,
  input  logic [DATA_BUS_W-1:0] data,
  input  logic                  last,
  output logic                  ready,
  output logic                  take,
  output logic [DATA_BUS_W-1:0] data_m,
  output logic                  last_m
);
  assign ready  = hit & en;
  assign take   = ready & valid;
  assign data_m = hit ? data : '0;
  assign last_m = hit & last;
endmodule

module axicb_pipe_arbiter #(
  parameter int NB_REQ     = 4,
  parameter int DATA_BUS_W = 8,
  parameter int PKT_MODE   = 1
) (
  input logic                 aclk,
  input logic                 aresetn,
  input logic                 srst,
  axicb_pipe_arbiter_if.slave bus
);
  localparam int PW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                              state;
  logic [PW-1:0]                       ptr;
  logic [PW-1:0]                       owner;
  logic [PW-1:0]                       sel;
  logic [PW:0]                         idx;
  logic                                sel_en;
  logic                                full;
  logic                                acc_en;
  logic                                accept;
  logic [PW-1:0]                       nxt_ptr;
  logic [NB_REQ-1:0]                   rdy;
  logic [NB_REQ-1:0]                   take;
  logic [NB_REQ-1:0][DATA_BUS_W-1:0]   dmask;
  logic [NB_REQ-1:0]                   lmask;
  logic [DATA_BUS_W-1:0]               sel_data;
  logic                                sel_last;

  logic                                ov_q;
  logic [DATA_BUS_W-1:0]               od_q;
  logic                                ol_q;
  logic [NB_REQ-1:0]                   og_q;

  // Output register cannot take a beat while it holds one that is stalled.
  assign full   = ov_q & ~bus.o_ready;
  // Nothing is accepted while either reset is active, so no beat slips in
  // and gets silently dropped by the reset edge.
  assign acc_en = ~full & aresetn & ~srst;

  // Winner select: LOCKED forces the owner; IDLE scans ptr, ptr+1, ... with
  // wrap. Scanning offsets high-to-low lets the lowest offset win.
  always_comb begin
    sel    = owner;
    sel_en = 1'b0;
    idx    = '0;
    if (state == LOCKED) begin
      sel    = owner;
      sel_en = 1'b1;
    end else begin
      for (int i = NB_REQ-1; i >= 0; i--) begin
        idx = {1'b0, ptr} + (PW+1)'(i);
        if (idx >= (PW+1)'(NB_REQ)) idx = idx - (PW+1)'(NB_REQ);
        if (bus.i_valid[idx[PW-1:0]]) begin
          sel    = idx[PW-1:0];
          sel_en = 1'b1;
        end
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < NB_REQ; k++) begin : g_lane
      axicb_pipe_arbiter_lane #(.DATA_BUS_W(DATA_BUS_W)) u_lane (
        .hit    (sel_en && (sel == PW'(k))),
        .en     (acc_en),
        .valid  (bus.i_valid[k]),
        .data   (bus.i_data[k*DATA_BUS_W +: DATA_BUS_W]),
        .last   (bus.i_last[k]),
        .ready  (rdy[k]),
        .take   (take[k]),
        .data_m (dmask[k]),
        .last_m (lmask[k])
      );
    end
  endgenerate

  assign bus.i_ready = rdy;
  assign accept      = |take;

  // Selected payload: masked lanes OR-reduced (only one lane is non-zero).
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      sel_data = sel_data | dmask[i];
      sel_last = sel_last | lmask[i];
    end
  end

  // Priority moves just past the requester that finished; sel equals owner
  // when LOCKED so one expression covers both states.
  assign nxt_ptr = (sel == PW'(NB_REQ-1)) ? '0 : sel + 1'b1;

  // Output stage plus grant FSM; both resets clear everything incl. the
  // in-flight beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ov_q  <= 1'b0;
      od_q  <= '0;
      ol_q  <= 1'b0;
      og_q  <= '0;
      ptr   <= '0;
      owner <= '0;
      state <= IDLE;
    end else if (srst) begin
      ov_q  <= 1'b0;
      od_q  <= '0;
      ol_q  <= 1'b0;
      og_q  <= '0;
      ptr   <= '0;
      owner <= '0;
      state <= IDLE;
    end else begin
      if (!full) begin
        ov_q <= accept;
        og_q <= take;
        if (accept) begin
          od_q <= sel_data;
          ol_q <= sel_last;
        end
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if ((PKT_MODE != 0) && !sel_last) begin
              owner <= sel;
              state <= LOCKED;
            end else begin
              ptr <= nxt_ptr;
            end
          end
        end
        LOCKED: begin
          if (accept && sel_last) begin
            ptr   <= nxt_ptr;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_valid = ov_q;
  assign bus.o_data  = od_q;
  assign bus.o_last  = ol_q;
  assign bus.o_grant = og_q;
endmodule

// File: doc/axicb_pipe_arbiter.md
Name: axicb_pipe_arbiter

Overview:
- Shares one registered valid/ready output channel between NB_REQ requesters with round-robin fairness.
- Sits in front of a crossbar pipeline stage, for example where several slave-side channels feed one master-side channel.
- Two grant modes:
  - Packet mode: the grant is held from the first beat to the beat carrying last.
  - Beat mode: the grant is re-arbitrated after every accepted beat.
- Output is one register stage whose timing matches the crossbar's single-stage pipeline, so it can drop into existing paths.

Parameters:
- NB_REQ, 4, number of requesters (2..16).
- DATA_BUS_W, 8, payload width in bits.
- PKT_MODE, 1. 1 = hold grant until the last beat is accepted; 0 = rotate priority after every accepted beat.

Ports:
- aclk  input  1  clock.
- aresetn  input  1  asynchronous active-low reset.
- srst  input  1  synchronous active-high reset, same effect as aresetn.
- i_valid  input  NB_REQ  per-requester valid.
- i_ready  output  NB_REQ  per-requester ready.
- i_data  input  NB_REQ*DATA_BUS_W  per-requester payload; requester k occupies bits [k*DATA_BUS_W +: DATA_BUS_W].
- i_last  input  NB_REQ  per-requester end-of-packet flag.
- o_valid  output  1  registered output valid.
- o_ready  input  1  downstream ready.
- o_data  output  DATA_BUS_W  registered output payload.
- o_last  output  1  registered output last.
- o_grant  output  NB_REQ  one-hot owner of the beat currently in the output register; zero when o_valid=0.

Behaviour:
- Reset (aresetn low, asynchronous; or srst high at a clock edge):
  - o_valid=0, o_data=0, o_last=0, o_grant=0.
  - Priority pointer = 0 (requester 0 highest priority).
  - FSM = IDLE.
- Output stage:
  - full = o_valid & ~o_ready.
  - The register loads whenever ~full.
  - Loading with no accepted beat clears o_valid to 0.
- Accepted beat: i_valid[k] & i_ready[k] at a rising edge.
  - Accepted beats are transferred in order with no loss or duplication.
  - Latency is exactly 1 cycle from acceptance to o_valid.
  - Sustained throughput is 1 beat/cycle while o_ready=1.
- Winner selection:
  - Search order is ptr, ptr+1, ..., NB_REQ-1, 0, ..., ptr-1.
  - The first requester with i_valid=1 wins.
  - Selection is combinational from i_valid and ptr.
- i_ready:
  - i_ready[k] = (k == selected) & ~full.
  - At most one bit is set.
  - i_ready may depend on i_valid; no requester may depend on i_ready to assert i_valid.
- FSM states:
  - IDLE: no packet in progress. The winner is chosen by round-robin.
    - Winner beat accepted with i_last=1 (or PKT_MODE=0): ptr <= winner+1 mod NB_REQ; stay in IDLE.
    - Winner beat accepted with i_last=0 and PKT_MODE=1: owner <= winner; go to LOCKED.
  - LOCKED: the selection is forced to owner; other requesters see i_ready=0 even when owner's i_valid=0.
    - Owner beat accepted with i_last=1: ptr <= owner+1 mod NB_REQ; go to IDLE.
- Boundary conditions:
  - No requester valid: no acceptance; ptr and state unchanged.
  - Owner deasserts i_valid mid-packet: the grant is still held; no other requester may interleave.
  - full for many cycles: selection and ptr are frozen (no acceptance); i_valid may change freely.
  - Wrap-around: ptr = NB_REQ-1 followed by acceptance from NB_REQ-1 gives ptr = 0.
  - Reset mid-packet: FSM returns to IDLE, the in-flight output beat is dropped, ptr = 0.
  - Simultaneous output drain and new acceptance in the same cycle: both occur; the output register holds the new beat.
- Fairness: with all NB_REQ requesters continuously valid, the grant sequence is 0,1,...,NB_REQ-1,0,... with packet granularity in PKT_MODE=1 and beat granularity in PKT_MODE=0.

Test Plan:
- Reset: hold aresetn=0 with all i_valid=1 → o_valid=0, i_ready=0000, o_grant=0. After release with o_ready=1, req0 is accepted first; its beat appears on o_data 1 cycle later with o_grant=0001.
- Fairness, PKT_MODE=0, NB_REQ=4: all valid, single-beat packets with data=k, o_ready=1 → o_data sequence 0,1,2,3,0,1,... at 1 beat/cycle.
- Packet lock, PKT_MODE=1: req1 sends 3 beats (last on the 3rd) while req2 stays valid → o_data = 1a,1b,1c then 2x; i_ready[2]=0 for those 3 cycles. Insert a 2-cycle gap in req1 valid → req2 is still blocked.
- Backpressure: o_ready=0 for 5 cycles with an output beat pending → o_valid/o_data/o_last stable, all i_ready=0, ptr unchanged. On o_ready=1, the next beat is accepted the same cycle and no beat is lost or duplicated.
- Wrap-around: only req3 and req0 valid, ptr=3 → req3 granted, then req0, then req3.
- Reset mid-packet: assert srst after beat 2 of a 4-beat req2 packet → next cycle o_valid=0, FSM IDLE, ptr=0. With req0 and req2 both valid, req0 wins next.
